// File: rtl/inst_fetch_buf.sv
// Fetch unit: owns the PC, fetches from inst_rom into a prefetch FIFO and hands {pc, inst} to ID.
// Latency: a word fetched in cycle N is at the head in cycle N+1. Stall holds the head and fetch stops when full.
// Optional macro FETCH_ALIGN_CHK_EN: word-align branch targets and pulse fetch_err_o on a misaligned target.
module inst_fetch_buf #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        fetch_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [31:0]   pc_q;
  logic          ce_q;
  logic [AW:0]   count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          pop;
  logic          push;
  logic [31:0]   target;

  assign pop      = id_valid_o & ~stall_i;
  // A full FIFO may still push when the head leaves in the same cycle.
  assign push     = ce_q & ~branch_flag_i & ((count < FULL_CNT) | pop);
  assign rom_ce_o = push;
  assign rom_addr_o = pc_q;

`ifdef FETCH_ALIGN_CHK_EN
  logic err_q;
  assign target = {branch_target_i[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= branch_flag_i & (|branch_target_i[1:0]);
  end
  assign fetch_err_o = err_q;
`else
  assign target      = branch_target_i;
  assign fetch_err_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      ce_q   <= 1'b0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      ce_q <= 1'b1;
      if (branch_flag_i) begin
        pc_q   <= target;
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          pc_q   <= pc_q + 32'd4;
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage is not reset; empty-state outputs are masked below.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: pc_q, inst: rom_data_i};
  end

  assign id_valid_o = (count != '0);
  assign id_pc_o    = id_valid_o ? mem[rd_ptr].pc   : 32'h0;
  assign id_inst_o  = id_valid_o ? mem[rd_ptr].inst : 32'h0;

endmodule

// File: doc/inst_fetch_buf.md
Name: inst_fetch_buf

Overview:
Instruction fetch unit with a prefetch FIFO, sitting between the inst_rom (upstream) and the ID stage of the openmips core (downstream). Owns the PC and drives rom_ce_o/rom_addr_o. Captures the ROM's same-cycle combinational data into a small FIFO and presents {pc, inst} pairs to decode under a valid/stall handshake. Redirects and flushes on branch/jump.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
rom_ce_o  output  1  ROM chip enable; high in every cycle a fetch is issued
rom_addr_o  output  32  ROM byte address, equal to the PC register
rom_data_i  input  32  ROM instruction, combinational from rom_addr_o in the same cycle
stall_i  input  1  ID stage cannot accept this cycle
branch_flag_i  input  1  redirect request from ID
branch_target_i  input  32  redirect target address
id_valid_o  output  1  FIFO head is valid
id_pc_o  output  32  PC of the FIFO head
id_inst_o  output  32  instruction at the FIFO head
fetch_err_o  output  1  misaligned-target flag (optional feature only; constant 0 otherwise)

Behaviour:
- Reset is asynchronous and active-low on rst_n; all state is clocked on the rising edge of clk.
- Reset values: pc_q=RESET_PC; ce_q=0; FIFO count=0; rd/wr pointers=0; fetch_err_o=0. ce_q rises to 1 on the first clock edge after rst_n deasserts, so rom_ce_o=0 during reset and in the first cycle after it.
- rom_addr_o=pc_q. When rom_ce_o=0, rom_addr_o still shows pc_q; the ROM ignores it.
- pop = id_valid_o & ~stall_i.
- fetch_en = ce_q & ~branch_flag_i & (count<DEPTH | pop). rom_ce_o=fetch_en. A full FIFO accepts a push in the same cycle as a pop.
- Push when fetch_en=1:
  - write {pc_q, rom_data_i} at wr_ptr;
  - pc_q <= pc_q+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0);
  - wr_ptr increments modulo DEPTH.
- Fetch-to-decode latency: an instruction fetched in cycle N appears at the head no earlier than cycle N+1. Zero-latency bypass is not used.
- Outputs are driven from the head entry, registered storage. id_valid_o=(count!=0). When empty, id_pc_o=0 and id_inst_o=0 (NOP).
- Count update: +1 on push only, -1 on pop only, unchanged on both.
- stall_i=1: head and all entries are held. Fetching continues until the FIFO is full, then rom_ce_o=0.
- branch_flag_i=1 (has priority over push, pop and stall):
  - count, rd_ptr and wr_ptr <= 0;
  - pc_q <= branch_target_i;
  - no push this cycle.
  - Next cycle: id_valid_o=0 and the fetch starts at the target.
  - A pop coinciding with the branch is considered consumed by ID. Delay-slot sequencing is the core's responsibility.
- Branch asserted on consecutive cycles: the last target wins.
- Reset mid-operation: everything returns to the reset values immediately (asynchronously). FIFO contents are discarded.

Optional Feature:
Macro: FETCH_ALIGN_CHK_EN
- Defined: on a branch with branch_target_i[1:0]!=0:
  - pc_q <= {branch_target_i[31:2],2'b00};
  - fetch_err_o=1 for exactly one cycle, the cycle after the branch;
  - the flush proceeds as normal.
- Not defined: fetch_err_o is tied to 0 and the target is loaded unmodified. Low bits then pass straight through to rom_addr_o.

Test Plan:
- Reset release, stall_i=0, ROM word k=k+1 → rom_ce_o=0 in the first cycle, then fetches at 0,4,8,…; ID sees (0,1),(4,2),(8,3) on consecutive cycles.
- stall_i=1 held for 10 cycles from reset → exactly 4 pushes (PCs 0..C), then rom_ce_o=0; on release, 0,4,8,C drain in order, followed by 10.
- FIFO full with stall_i=0 → push and pop in the same cycle; count stays 4, no PC gap.
- branch_flag_i=1, target 0x40, with 3 entries queued and stall_i=1 → next cycle id_valid_o=0, rom_addr_o=0x40; the following cycle the head is (0x40, ROM[0x40]).
- pc_q=0xFFFFFFFC, fetch → next pc_q=0x00000000; head PC sequence ends …FFFC, 0000.
- FETCH_ALIGN_CHK_EN defined, target 0x43 → fetch_err_o pulses for 1 cycle, fetch resumes at 0x40; without the macro, rom_addr_o=0x43 and fetch_err_o stays 0.
